// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: miss-fill controller streaming one cache block from main memory into the I- or D-cache
//
// Ports:
//   clk, rst_n                        clock (rising edge), asynchronous active-low reset
//   icache_miss / icache_miss_addr    I-cache miss request and faulting byte address
//   dcache_miss / dcache_miss_addr    D-cache miss request and faulting byte address (wins arbitration)
//   mem_en / mem_addr                 one read request per cycle to pipelined main memory
//   mem_data / mem_data_valid         returned read data, in issue order
//   fill_sel                          0 = I-cache, 1 = D-cache is the fill target
//   fill_data / fill_word_idx         word and its index for the data-array write
//   fill_data_we                      data-array write enable
//   fill_tag_we / fill_tag_addr       tag/valid write on the final word, block base address
//   icache_busy / dcache_busy         fill in progress for that cache
//   fill_done                         one-cycle pulse when the block is complete
module cache_fill_ctrl #(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           icache_miss,
    input  logic [ADDR_W-1:0]              icache_miss_addr,
    input  logic                           dcache_miss,
    input  logic [ADDR_W-1:0]              dcache_miss_addr,
    output logic                           mem_en,
    output logic [ADDR_W-1:0]              mem_addr,
    input  logic [15:0]                    mem_data,
    input  logic                           mem_data_valid,
    output logic                           fill_sel,
    output logic [15:0]                    fill_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_idx,
    output logic                           fill_data_we,
    output logic                           fill_tag_we,
    output logic [ADDR_W-1:0]              fill_tag_addr,
    output logic                           icache_busy,
    output logic                           dcache_busy,
    output logic                           fill_done
);
    localparam int IW = $clog2(BLOCK_WORDS);
    // Byte offset within a block spans IW word bits plus the half-word bit.
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << (IW + 1)) - 1);
    localparam logic [IW:0]       ISSUE_END = (IW + 1)'(BLOCK_WORDS);
    localparam logic [IW-1:0]     RECV_LAST = IW'(BLOCK_WORDS - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [IW:0]       issue_q, issue_d;
    logic [IW-1:0]     recv_q, recv_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            base_q  <= '0;
            issue_q <= '0;
            recv_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            base_q  <= base_d;
            issue_q <= issue_d;
            recv_q  <= recv_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        base_d        = base_q;
        issue_d       = issue_q;
        recv_d        = recv_q;
        mem_en        = 1'b0;
        mem_addr      = '0;
        fill_data_we  = 1'b0;
        fill_data     = '0;
        fill_word_idx = '0;
        fill_tag_we   = 1'b0;
        fill_done     = 1'b0;
        if (state_q == IDLE) begin
            if (dcache_miss || icache_miss) begin
                sel_d   = dcache_miss;
                base_d  = (dcache_miss ? dcache_miss_addr : icache_miss_addr) & ~OFF_MASK;
                issue_d = '0;
                recv_d  = '0;
                state_d = FILL;
            end
        end else begin
            // Issue side runs ahead of the receive side by the memory latency.
            if (issue_q < ISSUE_END) begin
                mem_en   = 1'b1;
                mem_addr = base_q + ADDR_W'({issue_q, 1'b0});
                issue_d  = issue_q + (IW + 1)'(1);
            end
            if (mem_data_valid) begin
                fill_data_we  = 1'b1;
                fill_data     = mem_data;
                fill_word_idx = recv_q;
                recv_d        = recv_q + IW'(1);
                // Tag is written only with the last word so a block is never tagged partially filled.
                if (recv_q == RECV_LAST) begin
                    fill_tag_we = 1'b1;
                    fill_done   = 1'b1;
                    state_d     = IDLE;
                end
            end
        end
    end

    assign fill_sel      = sel_q;
    assign fill_tag_addr = base_q;
    assign icache_busy   = (state_q == FILL) && !sel_q;
    assign dcache_busy   = (state_q == FILL) && sel_q;
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: scoreboard bench for cache_fill_ctrl with a fixed-latency memory model
module tb_cache_fill_ctrl;
    localparam logic [15:0] K = 16'h5A3C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icache_miss, dcache_miss;
    logic [15:0] icache_miss_addr, dcache_miss_addr;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_data_valid;
    logic        fill_sel;
    logic [15:0] fill_data;
    logic [2:0]  fill_word_idx;
    logic        fill_data_we, fill_tag_we;
    logic [15:0] fill_tag_addr;
    logic        icache_busy, dcache_busy, fill_done;

    cache_fill_ctrl #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
        .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
        .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_data_valid(mem_data_valid),
        .fill_sel(fill_sel), .fill_data(fill_data), .fill_word_idx(fill_word_idx),
        .fill_data_we(fill_data_we), .fill_tag_we(fill_tag_we), .fill_tag_addr(fill_tag_addr),
        .icache_busy(icache_busy), .dcache_busy(dcache_busy), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Memory: latency 4, data = addr ^ K; not reset so in-flight reads return after a DUT reset.
    logic [3:0]  pv = '0;
    logic [15:0] pd [4];
    always @(posedge clk) begin
        pv    <= {pv[2:0], mem_en};
        pd[0] <= mem_addr ^ K;
        pd[1] <= pd[0];
        pd[2] <= pd[1];
        pd[3] <= pd[2];
    end
    assign mem_data_valid = pv[3];
    assign mem_data       = pd[3];

    typedef struct packed {
        logic        sel;
        logic [2:0]  idx;
        logic [15:0] data;
        logic        last;
        logic [15:0] tag;
    } wexp_t;

    wexp_t       qw[$];
    logic [16:0] qa[$];
    wexp_t       e;
    logic [16:0] a;
    int          errs = 0, checks = 0, nwr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_fill(input logic sel, input logic [15:0] addr);
        logic [15:0] base;
        base = addr & 16'hFFF0;
        for (int i = 0; i < 8; i++) begin
            qa.push_back({sel, base + 16'(2 * i)});
            qw.push_back('{sel, 3'(i), (base + 16'(2 * i)) ^ K, i == 7, base});
        end
    endtask

    // Monitor: compares every issued read and every cache write against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_en) begin
                if (qa.size() == 0) chk("unexpected_mem_en", 1, 0);
                else begin
                    a = qa.pop_front();
                    chk("mem_issue", {fill_sel, mem_addr}, a);
                end
            end
            if (fill_data_we) begin
                if (qw.size() == 0) chk("unexpected_we", 1, 0);
                else begin
                    e = qw.pop_front();
                    chk("fill_write", {fill_sel, fill_word_idx, fill_data}, {e.sel, e.idx, e.data});
                    chk("tag_done", {fill_tag_we, fill_done, fill_tag_addr}, {e.last, e.last, e.tag});
                    chk("busy", {icache_busy, dcache_busy}, {!e.sel, e.sel});
                    nwr++;
                end
            end else if (fill_tag_we || fill_done) chk("stray_tag_done", 1, 0);
        end
    end

    // Caches drop their miss once their fill completes.
    logic drop_sel;
    initial forever begin
        @(negedge clk);
        if (fill_done) begin
            drop_sel = fill_sel;
            @(posedge clk);
            #1;
            if (drop_sel) dcache_miss = 1'b0;
            else icache_miss = 1'b0;
        end
    end

    task automatic raise(input logic d, input logic [15:0] addr, output int t0);
        @(posedge clk);
        #1;
        if (d) begin
            dcache_miss = 1'b1;
            dcache_miss_addr = addr;
        end else begin
            icache_miss = 1'b1;
            icache_miss_addr = addr;
        end
        push_fill(d, addr);
        t0 = cyc;
    endtask

    task automatic drain(input string name);
        int k;
        for (k = 0; k < 200; k++) begin
            @(posedge clk);
            if (qw.size() == 0 && qa.size() == 0 && !icache_miss && !dcache_miss) break;
        end
        chk(name, k < 200, 1);
    endtask

    task automatic chk_zero(input string name);
        chk(name, {mem_en, mem_addr, fill_sel, fill_data, fill_word_idx, fill_data_we,
                   fill_tag_we, fill_tag_addr, icache_busy, dcache_busy, fill_done}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, dd, n0, k, sv, sw;
        rst_n = 1'b0;
        icache_miss = 1'b0;
        dcache_miss = 1'b0;
        icache_miss_addr = '0;
        dcache_miss_addr = '0;
        #12;
        chk_zero("reset_outputs");
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("idle_mem_en", mem_en, 0);

        // Single D miss, fill_done must land 12 cycles after the request cycle.
        raise(1'b1, 16'h1236, t0);
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (fill_done) break;
        end
        chk("d_done_latency", cyc - t0, 12);
        drain("d_single_drain");

        // Simultaneous misses: D first, I issues two cycles after D's fill_done.
        @(posedge clk);
        #1;
        dcache_miss = 1'b1;
        dcache_miss_addr = 16'h8008;
        icache_miss = 1'b1;
        icache_miss_addr = 16'h0040;
        push_fill(1'b1, 16'h8008);
        push_fill(1'b0, 16'h0040);
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (fill_done) break;
        end
        dd = cyc;
        chk("d_first_done_sel", fill_sel, 1);
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_en) break;
        end
        chk("i_start_gap", {fill_sel, 32'(cyc - dd)}, {1'b0, 32'd2});
        drain("simul_drain");

        // I miss withdrawn two cycles into FILL still completes the whole block.
        raise(1'b0, 16'h0A5C, t0);
        repeat (3) @(posedge clk);
        #1 icache_miss = 1'b0;
        drain("withdrawn_drain");

        // Reset after three words received; stale returns must not write.
        raise(1'b1, 16'h4ABC, t0);
        n0 = nwr;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (nwr == n0 + 3) break;
        end
        chk("three_words_seen", nwr - n0, 3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        dcache_miss = 1'b0;
        qw.delete();
        qa.delete();
        #1 chk_zero("midfill_reset_outputs");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        sv = 0;
        sw = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sv += int'(mem_data_valid);
            sw += int'(fill_data_we);
        end
        chk("stale_valid_present", sv > 0, 1);
        chk("stale_no_write", sw, 0);
        chk("post_reset_idle", {icache_busy, dcache_busy, mem_en}, 0);

        raise(1'b1, 16'h2468, t0);
        drain("post_reset_drain");

        // Top of address space.
        raise(1'b1, 16'hFFFE, t0);
        drain("top_addr_drain");

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
